// File: rtl/data_memory.sv
// Byte-lane data memory with combinational read and a self-sequencing zero-fill.
// Contents are only zeroed by walking the CLEAR state, never by reset.
module data_memory #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10,
    parameter int INIT_CLEAR  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        we,
    output logic [31:0]       rdata,
    input  logic              clr_req,
    output logic              ready,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_WORDS - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [31:0]       mem [DEPTH_WORDS];

    // Handshake: ready=1 means writes on we are accepted at the next rising edge
    // and rdata reflects mem[addr]; ready=0 means writes are dropped and rdata is 0.
    assign ready     = (state == S_READY);
    assign rdata     = ready ? mem[addr] : 32'h0;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    clr_cnt <= '0;
                    state   <= (INIT_CLEAR != 0) ? S_CLEAR : S_READY;
                end
                S_CLEAR: begin
                    // Hold the counter on the last word so the sweep never wraps.
                    if (clr_cnt == LAST_WORD) begin
                        state <= S_READY;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                S_READY: begin
                    if (clr_req) begin
                        state   <= S_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    // A write coinciding with clr_req still commits, since state is READY on that edge.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_cnt] <= 32'h0;
        end else if (state == S_READY) begin
            for (int k = 0; k < 4; k++) begin
                if (we[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: a cycle-level reference model feeds an expected queue
// that a negedge monitor drains against {ready, rdata}.
module tb_data_memory;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    we;
    logic [31:0]   rdata;
    logic          clr_req;
    logic          ready;
    logic [1:0]    state_dbg;

    data_memory #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .INIT_CLEAR(1)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .clr_req(clr_req), .ready(ready), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    string       name_q[$];

    // Reference model: memory image, ready flag, and edges left until ready rises.
    logic [31:0] ref_mem [DEPTH];
    bit          ref_ready;
    int          wait_cnt;
    bit          in_rst;

    always @(negedge clk) begin
        logic [32:0] e;
        string       n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if ({ready, rdata} !== e) begin
                errors++;
                $display("FAIL %s: got ready=%0b rdata=%h, expected ready=%0b rdata=%h",
                         n, ready, rdata, e[32], e[31:0]);
            end
        end
    end

    task automatic step(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] w,
                        input logic c, input string n);
        addr    = a;
        wdata   = d;
        we      = w;
        clr_req = c;
        exp_q.push_back(ref_ready ? {1'b1, ref_mem[a]} : 33'h0);
        name_q.push_back(n);
        @(posedge clk);
        if (!in_rst) begin
            if (ref_ready) begin
                for (int k = 0; k < 4; k++) begin
                    if (w[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
                end
                if (c) begin
                    ref_ready = 1'b0;
                    wait_cnt  = DEPTH;
                end
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    ref_ready = 1'b1;
                    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
                end
            end
        end
        #1;
    endtask

    task automatic rand_step(input string n);
        step(AW'($urandom_range(0, DEPTH - 1)), $urandom, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), n);
    endtask

    // Reset is raised just after an edge, so the first check lands before any
    // further rising edge and exercises the asynchronous path.
    task automatic reset_for(input int n);
        rst       = 1'b1;
        in_rst    = 1'b1;
        ref_ready = 1'b0;
        for (int i = 0; i < n; i++) rand_step("in_reset");
        rst      = 1'b0;
        in_rst   = 1'b0;
        wait_cnt = DEPTH + 1;
    endtask

    initial begin
        rst       = 1'b1;
        addr      = '0;
        wdata     = '0;
        we        = '0;
        clr_req   = 1'b0;
        in_rst    = 1'b1;
        ref_ready = 1'b0;
        wait_cnt  = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        reset_for(2);

        // Power-up clear with stray writes and clr_req pulses that must be ignored.
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i == 100) step(AW'(3), 32'hA5A5A5A5, 4'hF, 1'b0, "clear_write_addr3");
            else          rand_step("init_clear");
        end
        step(AW'(0),    32'h0, 4'h0, 1'b0, "read0_after_clear");
        step(AW'(511),  32'h0, 4'h0, 1'b0, "read511_after_clear");
        step(AW'(1023), 32'h0, 4'h0, 1'b0, "read1023_after_clear");
        step(AW'(3),    32'h0, 4'h0, 1'b0, "read3_after_clear");

        step(AW'(5), 32'hDEADBEEF, 4'hF,    1'b0, "write5_full");
        step(AW'(5), 32'h11111111, 4'b0100, 1'b0, "write5_lane2");
        step(AW'(5), 32'h0,        4'h0,    1'b0, "read5_merged");

        step(AW'(7), 32'hCAFEF00D, 4'hF, 1'b0, "rw7_same_cycle");
        step(AW'(7), 32'h0,        4'h0, 1'b0, "read7_next");

        // Random traffic concentrated on a few words; rare clr_req restarts a full clear.
        for (int i = 0; i < 600; i++) begin
            step(AW'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 399) == 0), "random");
        end
        while (!ref_ready) rand_step("random_clear_drain");

        step(AW'(9), 32'h12345678, 4'hF, 1'b0, "write9");
        step(AW'(9), 32'h0,        4'h0, 1'b0, "read9");
        step(AW'(9), 32'hFFFFFFFF, 4'hF, 1'b1, "clr_with_write9");
        for (int i = 0; i < DEPTH; i++) rand_step("clr_req_clear");
        step(AW'(9), 32'h0, 4'h0, 1'b0, "read9_after_clr");

        // Abort a clear at count 600 with reset, then require a full restart.
        reset_for(2);
        for (int i = 0; i < 601; i++) rand_step("clear_before_abort");
        reset_for(2);
        for (int i = 0; i < DEPTH + 1; i++) rand_step("clear_after_abort");
        for (int i = 0; i < 8; i++) step(AW'($urandom_range(0, DEPTH - 1)), 32'h0, 4'h0, 1'b0,
                                         "read_after_abort");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
